// File: rtl/axis_cabs_sched_if.sv
// Bus bundle for the cabs scheduler: N requesters in, core issue/return, merged result out.
// slave = scheduler side, master = surrounding fabric (sources, cabs core, consumer).
interface axis_cabs_sched_if #(
    parameter int unsigned NUM_SOURCES = 4,
    parameter int unsigned DATA_WIDTH  = 256,
    parameter int unsigned ID_WIDTH    = $clog2(NUM_SOURCES)
);
    logic [NUM_SOURCES-1:0]            s_axis_tvalid;
    logic [NUM_SOURCES-1:0]            s_axis_tready;
    logic [NUM_SOURCES*DATA_WIDTH-1:0] s_axis_tdata;

    logic                              c_axis_tvalid;
    logic                              c_axis_tready;
    logic [DATA_WIDTH-1:0]             c_axis_tdata;

    logic                              r_axis_tvalid;
    logic                              r_axis_tready;
    logic [DATA_WIDTH-1:0]             r_axis_tdata;
    logic [DATA_WIDTH-1:0]             r_axis_tdata_abs;

    logic                              m_axis_tvalid;
    logic                              m_axis_tready;
    logic [DATA_WIDTH-1:0]             m_axis_tdata;
    logic [DATA_WIDTH-1:0]             m_axis_tdata_abs;
    logic [ID_WIDTH-1:0]               m_axis_tid;

    modport slave (
        input  s_axis_tvalid, s_axis_tdata,
        output s_axis_tready,
        output c_axis_tvalid, c_axis_tdata,
        input  c_axis_tready,
        input  r_axis_tvalid, r_axis_tdata, r_axis_tdata_abs,
        output r_axis_tready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tdata_abs, m_axis_tid,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata,
        input  s_axis_tready,
        input  c_axis_tvalid, c_axis_tdata,
        output c_axis_tready,
        output r_axis_tvalid, r_axis_tdata, r_axis_tdata_abs,
        input  r_axis_tready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tdata_abs, m_axis_tid,
        output m_axis_tready
    );
endinterface

// File: rtl/axis_cabs_sched.sv
// Round-robin scheduler sharing one serial cabs core between NUM_SOURCES stream requesters.
// Issued source IDs go through an in-order tag FIFO and are re-attached to the core's results.
module axis_cabs_sched #(
    parameter int unsigned NUM_SOURCES  = 4,
    parameter int unsigned DATA_WIDTH   = 256,
    parameter int unsigned MAX_INFLIGHT = 16,
    parameter int unsigned ID_WIDTH     = $clog2(NUM_SOURCES)
) (
    input  logic                          clk,
    input  logic                          rst,
    axis_cabs_sched_if.slave              bus,
    output logic [$clog2(MAX_INFLIGHT):0] inflight,
    output logic                          err_orphan
);
    localparam int unsigned PtrWidth = $clog2(MAX_INFLIGHT);
    localparam int unsigned CntWidth = PtrWidth + 1;

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e              state_q;
    logic [ID_WIDTH-1:0] grant_id_q;
    logic [ID_WIDTH-1:0] rr_ptr_q;
    logic [PtrWidth-1:0] wr_ptr_q;
    logic [PtrWidth-1:0] rd_ptr_q;
    logic [CntWidth-1:0] count_q;
    logic                err_orphan_q;
    logic [ID_WIDTH-1:0] tag_mem [MAX_INFLIGHT];

    logic                grant_valid;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                room;
    logic [CntWidth-1:0] count_after;
    logic [ID_WIDTH-1:0] next_ptr;
    logic [ID_WIDTH-1:0] arb_ptr;
    logic [ID_WIDTH-1:0] arb_id;
    logic                arb_hit;

    assign grant_valid = (state_q == StGrant);
    assign fifo_empty  = (count_q == '0);

    // Issue side: only the granted source sees the core's ready.
    always_comb begin
        bus.c_axis_tvalid = 1'b0;
        bus.c_axis_tdata  = '0;
        bus.s_axis_tready = '0;
        for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
            if (grant_valid && (grant_id_q == ID_WIDTH'(k))) begin
                bus.c_axis_tvalid    = bus.s_axis_tvalid[k];
                bus.c_axis_tdata     = bus.s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
                bus.s_axis_tready[k] = bus.c_axis_tready;
            end
        end
    end

    assign push = bus.c_axis_tvalid & bus.c_axis_tready;

    // Return side: a result is only passed on when a tag exists for it.
    assign bus.m_axis_tvalid    = bus.r_axis_tvalid & ~fifo_empty;
    assign bus.r_axis_tready    = bus.m_axis_tready & ~fifo_empty;
    assign bus.m_axis_tdata     = bus.r_axis_tdata;
    assign bus.m_axis_tdata_abs = bus.r_axis_tdata_abs;
    assign bus.m_axis_tid       = fifo_empty ? '0 : tag_mem[rd_ptr_q];
    assign pop                  = bus.r_axis_tvalid & bus.r_axis_tready;

    // A held grant already owns a slot, so room is judged on post-push occupancy.
    assign count_after = count_q + CntWidth'(push) - CntWidth'(pop);
    assign room        = (count_after < CntWidth'(MAX_INFLIGHT));

    assign next_ptr = (grant_id_q == ID_WIDTH'(NUM_SOURCES - 1)) ? '0 : grant_id_q + ID_WIDTH'(1);
    assign arb_ptr  = push ? next_ptr : rr_ptr_q;

    always_comb begin
        int unsigned tgt;
        arb_hit = 1'b0;
        arb_id  = '0;
        tgt     = 0;
        for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
            tgt = int'(arb_ptr) + i;
            if (tgt >= NUM_SOURCES) begin
                tgt = tgt - NUM_SOURCES;
            end
            for (int unsigned j = 0; j < NUM_SOURCES; j++) begin
                if (!arb_hit && (j == tgt) && bus.s_axis_tvalid[j]) begin
                    arb_hit = 1'b1;
                    arb_id  = ID_WIDTH'(j);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arb_hit && room) begin
                        state_q    <= StGrant;
                        grant_id_q <= arb_id;
                    end
                end
                StGrant: begin
                    // Grant never moves while a beat is pending on the core port.
                    if (push) begin
                        rr_ptr_q <= next_ptr;
                        if (arb_hit && room) begin
                            grant_id_q <= arb_id;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
            end
            count_q <= count_after;
            if (bus.r_axis_tvalid && fifo_empty) begin
                err_orphan_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= grant_id_q;
        end
    end

    assign inflight   = count_q;
    assign err_orphan = err_orphan_q;
endmodule

// File: tb/tb_axis_cabs_sched.sv
// Bench for axis_cabs_sched: source models, a latency-2 cabs core model and an in-order scoreboard.
module tb_axis_cabs_sched;
    localparam int NS   = 4;
    localparam int DW   = 256;
    localparam int IW   = $clog2(NS);
    localparam int MAXI = 16;
    localparam int LAT  = 2;
    localparam logic [DW-1:0] ORPH = {8{32'hdead_beef}};

    logic                  clk;
    logic                  rst;
    logic [$clog2(MAXI):0] inflight;
    logic                  err_orphan;

    axis_cabs_sched_if #(.NUM_SOURCES(NS), .DATA_WIDTH(DW)) bus ();

    axis_cabs_sched #(
        .NUM_SOURCES (NS),
        .DATA_WIDTH  (DW),
        .MAX_INFLIGHT(MAXI)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .inflight  (inflight),
        .err_orphan(err_orphan)
    );

    typedef struct {int id; logic [DW-1:0] data;} sb_t;
    typedef struct {logic [DW-1:0] data; int rdy;} core_t;

    sb_t   sb[$];
    core_t core_q[$];
    int    acc_log[$];
    int    src_cnt[NS];
    int    seq[NS];
    int    cyc;
    int    m_count;
    int    n_checks;
    int    n_fail;
    logic  orphan_force;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk_data(input int k, input int s);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) begin
            d[i*32 +: 32] = {k[7:0], i[7:0], s[15:0]};
        end
        return d;
    endfunction

    // Sources and core model update just after the active edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        for (int k = 0; k < NS; k++) begin
            bus.s_axis_tvalid[k]         = (src_cnt[k] != 0);
            bus.s_axis_tdata[k*DW +: DW] = mk_data(k, seq[k]);
        end
        if (orphan_force) begin
            bus.r_axis_tvalid    = 1'b1;
            bus.r_axis_tdata     = ORPH;
            bus.r_axis_tdata_abs = ~ORPH;
        end else if (core_q.size() > 0 && core_q[0].rdy <= cyc) begin
            bus.r_axis_tvalid    = 1'b1;
            bus.r_axis_tdata     = core_q[0].data;
            bus.r_axis_tdata_abs = ~core_q[0].data;
        end else begin
            bus.r_axis_tvalid    = 1'b0;
            bus.r_axis_tdata     = '0;
            bus.r_axis_tdata_abs = '0;
        end
    end

    // Monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        int hs_n;
        int hs_k;
        logic c_fire;
        logic m_fire;
        logic r_fire;
        sb_t e;
        if (!rst) begin
            hs_n = 0;
            hs_k = 0;
            for (int k = 0; k < NS; k++) begin
                if (bus.s_axis_tvalid[k] && bus.s_axis_tready[k]) begin
                    hs_n++;
                    hs_k = k;
                end
            end
            c_fire = bus.c_axis_tvalid && bus.c_axis_tready;
            m_fire = bus.m_axis_tvalid && bus.m_axis_tready;
            r_fire = bus.r_axis_tvalid && bus.r_axis_tready;
            n_checks++;
            if (hs_n != (c_fire ? 1 : 0)) begin
                n_fail++;
                $display("FAIL s_handshake: got %0d source handshakes, want %0d", hs_n, c_fire);
            end
            if (c_fire && hs_n == 1) begin
                n_checks++;
                if (bus.c_axis_tdata !== mk_data(hs_k, seq[hs_k])) begin
                    n_fail++;
                    $display("FAIL c_tdata: got %h want %h", bus.c_axis_tdata[31:0],
                             mk_data(hs_k, seq[hs_k]) & 32'hffff_ffff);
                end
                core_q.push_back('{data: bus.c_axis_tdata, rdy: cyc + LAT});
                sb.push_back('{id: hs_k, data: mk_data(hs_k, seq[hs_k])});
                acc_log.push_back(hs_k);
                seq[hs_k]++;
                if (src_cnt[hs_k] > 0) src_cnt[hs_k]--;
            end
            n_checks++;
            if (r_fire !== m_fire) begin
                n_fail++;
                $display("FAIL r_m_handshake: got r=%0b m=%0b want equal", r_fire, m_fire);
            end
            if (r_fire && core_q.size() > 0) core_q.pop_front();
            if (m_fire) begin
                m_count++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL m_unexpected: got output tid %0d, want no output",
                             bus.m_axis_tid);
                end else begin
                    e = sb.pop_front();
                    if (bus.m_axis_tid !== IW'(e.id) || bus.m_axis_tdata !== e.data ||
                        bus.m_axis_tdata_abs !== ~e.data) begin
                        n_fail++;
                        $display("FAIL m_beat: got tid %0d data %h, want tid %0d data %h",
                                 bus.m_axis_tid, bus.m_axis_tdata[31:0], e.id, e.data[31:0]);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst          = 1'b1;
        orphan_force = 1'b0;
        for (int k = 0; k < NS; k++) src_cnt[k] = 0;
        bus.c_axis_tready = 1'b0;
        bus.m_axis_tready = 1'b0;
        core_q.delete();
        sb.delete();
        acc_log.delete();
        m_count = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        orphan_force = 1'b1;
        for (int k = 0; k < NS; k++) src_cnt[k] = 1;
        bus.c_axis_tready = 1'b1;
        bus.m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.s_axis_tready !== '0 || bus.c_axis_tvalid !== 1'b0 || bus.c_axis_tdata !== '0) begin
            n_fail++;
            $display("FAIL reset_issue: got s_tready %b c_tvalid %b, want 0 0",
                     bus.s_axis_tready, bus.c_axis_tvalid);
        end
        n_checks++;
        if (bus.m_axis_tvalid !== 1'b0 || bus.r_axis_tready !== 1'b0 || bus.m_axis_tid !== '0) begin
            n_fail++;
            $display("FAIL reset_return: got m_tvalid %b r_tready %b tid %0d, want 0 0 0",
                     bus.m_axis_tvalid, bus.r_axis_tready, bus.m_axis_tid);
        end
        n_checks++;
        if (inflight !== '0 || err_orphan !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: got inflight %0d err %b, want 0 0", inflight, err_orphan);
        end
        n_checks++;
        if (bus.m_axis_tdata !== ORPH || bus.m_axis_tdata_abs !== ~ORPH) begin
            n_fail++;
            $display("FAIL reset_passthru: got %h want %h", bus.m_axis_tdata[31:0], ORPH[31:0]);
        end
        do_reset();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < NS; k++) src_cnt[k] = 1000;
        bus.c_axis_tready = 1'b1;
        bus.m_axis_tready = 1'b1;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (inflight !== ($clog2(MAXI) + 1)'(LAT)) begin
                n_fail++;
                $display("FAIL rr_inflight: got %0d want %0d", inflight, LAT);
            end
        end
        n_checks++;
        if (acc_log.size() < 12) begin
            n_fail++;
            $display("FAIL rr_count: got %0d beats want >= 12", acc_log.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                n_checks++;
                if (acc_log[i] !== i % NS) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: got %0d want %0d", i, acc_log[i], i % NS);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [3:0]    pat;
        logic [DW-1:0] snap;
        bit            seen;
        pat = 4'b1001;
        do_reset();
        bus.m_axis_tready = 1'b1;
        src_cnt[2] = 100;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.c_axis_tvalid;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL stall_grant: got c_tvalid 0 after 10 cycles, want 1");
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            bus.c_axis_tready = pat[i];
            snap = mk_data(2, seq[2]);
            @(negedge clk);
            n_checks++;
            if (bus.c_axis_tvalid !== 1'b1 || bus.c_axis_tdata !== snap) begin
                n_fail++;
                $display("FAIL stall_data[%0d]: got v=%b %h want v=1 %h", i, bus.c_axis_tvalid,
                         bus.c_axis_tdata[31:0], snap[31:0]);
            end
            n_checks++;
            if ((bus.s_axis_tready & 4'b1011) !== 4'b0000 || bus.s_axis_tready[2] !== pat[i]) begin
                n_fail++;
                $display("FAIL stall_ready[%0d]: got %b want %b", i, bus.s_axis_tready,
                         {1'b0, pat[i], 2'b00});
            end
        end
        @(posedge clk);
        #2;
        bus.c_axis_tready = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (acc_log.size() !== 2 || acc_log[0] !== 2 || acc_log[1] !== 2) begin
            n_fail++;
            $display("FAIL stall_beats: got %0d beats want 2 from source 2", acc_log.size());
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < NS; k++) src_cnt[k] = 1000;
        bus.c_axis_tready = 1'b1;
        repeat (40) @(negedge clk);
        n_checks++;
        if (acc_log.size() !== MAXI || bus.c_axis_tvalid !== 1'b0 || inflight !== MAXI) begin
            n_fail++;
            $display("FAIL bp_full: got beats %0d c_tvalid %b inflight %0d, want %0d 0 %0d",
                     acc_log.size(), bus.c_axis_tvalid, inflight, MAXI, MAXI);
        end
        for (int k = 0; k < NS; k++) src_cnt[k] = 0;
        @(posedge clk);
        #2;
        bus.m_axis_tready = 1'b1;
        for (int i = 0; i < 60 && m_count < MAXI; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        n_checks++;
        if (m_count !== MAXI || inflight !== '0) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d outputs inflight %0d, want %0d 0",
                     m_count, inflight, MAXI);
        end
        for (int i = 0; i < acc_log.size(); i++) begin
            n_checks++;
            if (acc_log[i] !== i % NS) begin
                n_fail++;
                $display("FAIL bp_order[%0d]: got %0d want %0d", i, acc_log[i], i % NS);
            end
        end
    endtask

    task automatic test_rr_fairness();
        int  want[5];
        bit  seen;
        want = '{2, 3, 1, 3, 1};
        do_reset();
        bus.m_axis_tready = 1'b1;
        src_cnt[2] = 1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.c_axis_tvalid;
        end
        src_cnt[1] = 2;
        src_cnt[3] = 2;
        @(posedge clk);
        #2;
        bus.c_axis_tready = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (acc_log.size() !== 5) begin
            n_fail++;
            $display("FAIL fair_count: got %0d beats want 5", acc_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (acc_log[i] !== want[i]) begin
                    n_fail++;
                    $display("FAIL fair_order[%0d]: got %0d want %0d", i, acc_log[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_orphan();
        do_reset();
        bus.m_axis_tready = 1'b1;
        orphan_force = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (err_orphan !== 1'b0 || bus.m_axis_tvalid !== 1'b0 || bus.r_axis_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL orphan_first: got err %b m_tvalid %b r_tready %b, want 0 0 0",
                     err_orphan, bus.m_axis_tvalid, bus.r_axis_tready);
        end
        n_checks++;
        if (bus.m_axis_tdata !== ORPH) begin
            n_fail++;
            $display("FAIL orphan_passthru: got %h want %h", bus.m_axis_tdata[31:0], ORPH[31:0]);
        end
        @(negedge clk);
        n_checks++;
        if (err_orphan !== 1'b1 || bus.m_axis_tvalid !== 1'b0 || bus.r_axis_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL orphan_set: got err %b m_tvalid %b r_tready %b, want 1 0 0",
                     err_orphan, bus.m_axis_tvalid, bus.r_axis_tready);
        end
        orphan_force = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (err_orphan !== 1'b1) begin
            n_fail++;
            $display("FAIL orphan_sticky: got %b want 1", err_orphan);
        end
        do_reset();
        n_checks++;
        if (err_orphan !== 1'b0) begin
            n_fail++;
            $display("FAIL orphan_clear: got %b want 0", err_orphan);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit seen;
        do_reset();
        for (int k = 0; k < NS; k++) src_cnt[k] = 1000;
        bus.c_axis_tready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = (inflight == 5);
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL mid_fill: got inflight %0d want 5", inflight);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (inflight !== '0 || bus.s_axis_tready !== '0 || bus.c_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async: got inflight %0d s_tready %b c_tvalid %b, want 0 0 0",
                     inflight, bus.s_axis_tready, bus.c_axis_tvalid);
        end
        core_q.delete();
        sb.delete();
        acc_log.delete();
        m_count = 0;
        bus.m_axis_tready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        n_checks++;
        if (acc_log.size() < 4) begin
            n_fail++;
            $display("FAIL mid_restart: got %0d beats want >= 4", acc_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (acc_log[i] !== i) begin
                    n_fail++;
                    $display("FAIL mid_order[%0d]: got %0d want %0d", i, acc_log[i], i);
                end
            end
        end
        n_checks++;
        if (err_orphan !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_orphan: got %b want 0", err_orphan);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        m_count  = 0;
        rst      = 1'b1;
        orphan_force = 1'b0;
        for (int k = 0; k < NS; k++) begin
            src_cnt[k] = 0;
            seq[k]     = 0;
        end
        bus.s_axis_tvalid    = '0;
        bus.s_axis_tdata     = '0;
        bus.c_axis_tready    = 1'b0;
        bus.r_axis_tvalid    = 1'b0;
        bus.r_axis_tdata     = '0;
        bus.r_axis_tdata_abs = '0;
        bus.m_axis_tready    = 1'b0;
        test_reset();
        test_round_robin();
        test_stall();
        test_backpressure();
        test_rr_fairness();
        test_orphan();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
